serial_adder_controller: RTL and testbench

Sequencer that performs a WIDTH-bit add or subtract over WIDTH clock cycles, one bit per cycle, using a single `full_adder` instance as its only arithmetic resource. It latches operands through a valid/ready input handshake and shifts them LSB-first through the adder, holding the ripple carry in a register between cycles. It presents the result, carry and signed overflow through a valid/ready output handshake. It sits as a low-area ALU alternative next to the Hack word datapath.

---
 rtl/hack_pkg.sv | 18 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_controller.sv | 131 +++++++++++++
 tb/tb_serial_adder_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack word datapath: the word width and the
// serial adder's sequencing states.
package hack_pkg;

  localparam int HACK_WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } serial_state_t;

  // Signed overflow of an add: carry into the MSB disagrees with carry out of it.
  function automatic logic signed_overflow(input logic c_in, input logic c_out);
    return c_in ^ c_out;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder. This is the only arithmetic resource in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_controller.sv
// Bit-serial add/subtract: operands shift LSB-first through one full_adder and
// the ripple carry is held in a register. Subtract feeds ~b with carry-in 1.
module serial_adder_controller
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  serial_state_t    state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] res_sh_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_sum_s;
  logic             fa_carry_s;
  logic             last_bit_s;
  logic             accept_s;
  logic [WIDTH-1:0] res_cat_s;

  full_adder u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .sum   (fa_sum_s),
    .carry (fa_carry_s)
  );

  assign last_bit_s = (cnt_q == CNT_W'(WIDTH - 1));
  assign accept_s   = (state_q == IDLE) && in_valid;
  // New sum bit enters at the top; after the final shift this is the whole word.
  assign res_cat_s  = {fa_sum_s, res_sh_q};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = SHIFT;
        else          state_d = IDLE;
      end
      SHIFT: begin
        if (last_bit_s) state_d = DONE;
        else            state_d = SHIFT;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      SHIFT:   in_ready  = 1'b0;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand/result shift registers, ripple carry, bit counter and result latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept_s) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub;
      cnt_q   <= '0;
    end else if (state_q == SHIFT) begin
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      res_sh_q <= res_cat_s[WIDTH-1:1];
      carry_q  <= fa_carry_s;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last_bit_s) begin
        result_q <= res_cat_s;
        cout_q   <= fa_carry_s;
        ovf_q    <= signed_overflow(carry_q, fa_carry_s);
      end else begin
        result_q <= result_q;
      end
    end else begin
      a_q <= a_q;
    end
  end

  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_controller.sv
// Directed bench for serial_adder_controller (WIDTH=16) with a result scoreboard
// fed at each accept edge and drained by an independent output monitor.
module tb_serial_adder_controller;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t sb_q[$];

  serial_adder_controller #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation; 'track' pushes the expected response at the accept edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                      input logic [W-1:0] er, input logic ec, input logic eo,
                      input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    @(posedge clk);
    if (track) sb_q.push_back('{res: er, cout: ec, ovf: eo});
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  // Leaves the caller at the first negedge with out_valid high.
  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Output monitor: latency on each rising out_valid, scoreboard compare on consume.
  initial begin
    exp_t e;
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid && !prev_ov) chk("latency", 32'(cyc - acc_cyc), 32'd16);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", 32'(result), 32'hDEAD);
          end else begin
            e = sb_q.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("carry_out", 32'(carry_out), 32'(e.cout));
            chk("overflow", 32'(overflow), 32'(e.ovf));
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic         vs [5];
    logic [W-1:0] vr [5];
    logic         vc [5];
    logic         vo [5];
    int ov_seen;
    va = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234};
    vb = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h1234};
    vs = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1};
    vr = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000};
    vc = '{1'b1,     1'b0,     1'b0,     1'b1,     1'b1};
    vo = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    out_ready = 1'b1;
    send(16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b1);
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    wait_done();
    chk("done_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ov_one_cycle", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      send(va[i], vb[i], vs[i], vr[i], vc[i], vo[i], 1'b1);
      wait_done();
    end

    // Backpressure with a competing request held on the input.
    @(posedge clk); #1 out_ready = 1'b0;
    send(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b1);
    wait_done();
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result", 32'(result), 32'h0030);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back('{res: 16'h3333, cout: 1'b0, ovf: 1'b0});
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 32'(in_ready), 32'd0);
    wait_done();

    // Reset at the bit-7 edge of an in-flight add.
    send(16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_carry", 32'(carry_out), 32'd0);
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen = ov_seen + 1;
    end
    chk("mid_rst_no_valid", 32'(ov_seen), 32'd0);
    send(16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b1);
    wait_done();

    // Operand pins toggle throughout SHIFT; only latched values may count.
    send(16'h1357, 16'h0246, 1'b0, 16'h159D, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    end
    wait_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
